// File: rtl/regfile_pkg.sv
// Shared register-file types: widths, the zero register and the write-back request record.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // r0 is hard-wired, so it never appears in a pending bitmap
  function automatic logic [NUM_REGS-1:0] regOneHot(input logic [ADDR_W-1:0] r);
    regOneHot    = '0;
    regOneHot[r] = (r != ZERO_REG);
  endfunction
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Write-back request, register-file write port, pending bitmap and forwarding lookup.
interface regfile_writeback_queue_if;
  import regfile_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_reg;
  logic [DATA_W-1:0]   in_data;
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_reg;
  logic [DATA_W-1:0]   wb_data;
  logic [NUM_REGS-1:0] pending;
  logic [ADDR_W-1:0]   q_reg;
  logic                q_hit;
  logic [DATA_W-1:0]   q_data;
  logic                empty;

  modport master (
    output in_valid, in_reg, in_data, q_reg,
    input  in_ready, wb_en, wb_reg, wb_data, pending, q_hit, q_data, empty
  );

  modport slave (
    input  in_valid, in_reg, in_data, q_reg,
    output in_ready, wb_en, wb_reg, wb_data, pending, q_hit, q_data, empty
  );
endinterface

// File: rtl/regfile_writeback_queue_fifo.sv
// Write-back request FIFO; exposes raw slots, per-slot validity and oldest-to-youngest slot order.
module wbq_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_req_t          pushEntry,
  output wb_req_t          headEntry,
  output wb_req_t          entries [DEPTH],
  output logic [DEPTH-1:0] validMask,
  output logic [PTR_W-1:0] ageOrder [DEPTH],
  output logic             full,
  output logic             empty
);
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             pushOk;
  logic             popOk;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign pushOk    = push && !full;
  assign popOk     = pop && !empty;
  assign headEntry = entries[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(pushOk) - CNT_W'(popOk);
    end
  end

  // Slot contents need no reset; validMask gates every consumer
  always_ff @(posedge clk) begin
    if (pushOk) entries[wrPtr] <= pushEntry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ageOrder[i]  = rdPtr + PTR_W'(i);
      validMask[i] = ({1'b0, PTR_W'(PTR_W'(i) - rdPtr)} < count);
    end
  end
endmodule

// File: rtl/regfile_writeback_queue.sv
// Queues register write-backs and drains one per cycle onto the register-file write port,
// publishing a pending bitmap and a youngest-value forwarding lookup.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  regfile_writeback_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t             entries [DEPTH];
  wb_req_t             headEntry;
  wb_req_t             incoming;
  logic [DEPTH-1:0]    validMask;
  logic [PTR_W-1:0]    ageOrder [DEPTH];
  logic                fifoFull;
  logic                fifoEmpty;
  logic                pushReq;
  logic                wbEn;
  logic [ADDR_W-1:0]   wbReg;
  logic [DATA_W-1:0]   wbData;
  logic [NUM_REGS-1:0] pendingMap;
  logic                hit;
  logic [DATA_W-1:0]   fwdData;

  assign incoming = '{dest: bus.in_reg, data: bus.in_data};
  assign pushReq  = bus.in_valid && !fifoFull && (bus.in_reg != ZERO_REG);

  wbq_fifo #(.DEPTH(DEPTH)) fifoInst (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pushReq),
    .pop       (!fifoEmpty),
    .pushEntry (incoming),
    .headEntry (headEntry),
    .entries   (entries),
    .validMask (validMask),
    .ageOrder  (ageOrder),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  // Registered write port so the register file sees stable values at its negedge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbEn   <= 1'b0;
      wbReg  <= '0;
      wbData <= '0;
    end else if (!fifoEmpty) begin
      wbEn   <= 1'b1;
      wbReg  <= headEntry.dest;
      wbData <= headEntry.data;
    end else begin
      wbEn   <= 1'b0;
    end
  end

  // Walk wb stage then FIFO oldest-to-youngest, so the youngest match wins the forward
  always_comb begin
    pendingMap = '0;
    hit        = 1'b0;
    fwdData    = '0;
    if (wbEn) begin
      pendingMap = pendingMap | regOneHot(wbReg);
      if (wbReg == bus.q_reg) begin
        hit     = 1'b1;
        fwdData = wbData;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (validMask[ageOrder[k]]) begin
        pendingMap = pendingMap | regOneHot(entries[ageOrder[k]].dest);
        if (entries[ageOrder[k]].dest == bus.q_reg) begin
          hit     = 1'b1;
          fwdData = entries[ageOrder[k]].data;
        end
      end
    end
    if (bus.q_reg == ZERO_REG) begin
      hit     = 1'b0;
      fwdData = '0;
    end
  end

  assign bus.in_ready = !fifoFull;
  assign bus.wb_en    = wbEn;
  assign bus.wb_reg   = wbReg;
  assign bus.wb_data  = wbData;
  assign bus.pending  = pendingMap;
  assign bus.q_hit    = hit;
  assign bus.q_data   = fwdData;
  assign bus.empty    = fifoEmpty && !wbEn;
endmodule
